// File: rtl/layer_sequencer.sv
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Captures a parallel layer-L output vector and replays it serially
//            to layer L+1, one word per cycle, holding off until L+1 is done.
//            Optional macro DOUBLE_BUF_EN adds a one-vector pending buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_sequencer #(
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] up_data,
  input  logic                             up_valid,
  input  logic                             down_done,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             overflow,
  output logic [15:0]                      vec_count
);

  localparam int IDX_W = $clog2(NUM_NEURON + 1);
  localparam int VEC_W = NUM_NEURON * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [VEC_W-1:0] act_buf;

  logic accept;
  logic step;
  logic finish;
  logic drop;

`ifdef DOUBLE_BUF_EN
  logic [VEC_W-1:0] pend_buf;
  logic             pend_full;
  logic             promote;
  logic             to_pend;
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    drop       = 1'b0;
`ifdef DOUBLE_BUF_EN
    promote    = 1'b0;
    to_pend    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (up_valid) begin
          accept     = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        // idx points at the next word to emit; reaching NUM_NEURON means the last one is on the bus
        if (idx == IDX_W'(NUM_NEURON)) begin
          finish     = 1'b1;
          state_next = WAIT;
        end else begin
          step = 1'b1;
        end
        if (up_valid) begin
`ifdef DOUBLE_BUF_EN
          if (pend_full) drop = 1'b1;
          else           to_pend = 1'b1;
`else
          drop = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (down_done) begin
`ifdef DOUBLE_BUF_EN
          if (pend_full) begin
            promote    = 1'b1;
            state_next = STREAM;
            if (up_valid) to_pend = 1'b1;
          end else if (up_valid) begin
            accept     = 1'b1;
            state_next = STREAM;
          end else begin
            state_next = IDLE;
          end
`else
          if (up_valid) begin
            accept     = 1'b1;
            state_next = STREAM;
          end else begin
            state_next = IDLE;
          end
`endif
        end else if (up_valid) begin
`ifdef DOUBLE_BUF_EN
          if (pend_full) drop = 1'b1;
          else           to_pend = 1'b1;
`else
          drop = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      vec_count <= '0;
    end else begin
      state <= state_next;
      // Word 0 is taken straight from the source so it appears one cycle after capture
      if (accept) begin
        out_data  <= up_data[DATA_WIDTH-1:0];
        out_valid <= 1'b1;
        idx       <= IDX_W'(1);
`ifdef DOUBLE_BUF_EN
      end else if (promote) begin
        out_data  <= pend_buf[DATA_WIDTH-1:0];
        out_valid <= 1'b1;
        idx       <= IDX_W'(1);
`endif
      end else if (step) begin
        out_data  <= act_buf[DATA_WIDTH*int'(idx) +: DATA_WIDTH];
        out_valid <= 1'b1;
        idx       <= idx + IDX_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
      if (finish) vec_count <= vec_count + 16'd1;
      if (drop)   overflow  <= 1'b1;
    end
  end

  // Buffer contents are don't-care after reset, so they carry no reset
  always_ff @(posedge clk) begin
    if (accept) act_buf <= up_data;
`ifdef DOUBLE_BUF_EN
    else if (promote) act_buf <= pend_buf;
    if (to_pend) pend_buf <= up_data;
`endif
  end

`ifdef DOUBLE_BUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
    end else if (to_pend) begin
      pend_full <= 1'b1;
    end else if (promote) begin
      pend_full <= 1'b0;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with NUM_NEURON=4, DATA_WIDTH=16.
`default_nettype none

module tb_layer_sequencer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] up_data;
  logic            up_valid;
  logic            down_done;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            busy;
  logic            overflow;
  logic [15:0]     vec_count;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  layer_sequencer #(.NUM_NEURON(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid),
    .down_done(down_done), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .overflow(overflow), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Every streamed word must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got word %0h, expected no output", out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL stream_word: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] mk(input int base);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic send(input int base, input bit expect_stream);
    up_data  = mk(base);
    up_valid = 1'b1;
    if (expect_stream)
      for (int i = 0; i < N; i++) exp_q.push_back(DW'(base + i));
    tick();
    up_valid = 1'b0;
  endtask

  task automatic pulse_done();
    down_done = 1'b1;
    tick();
    down_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, busy, overflow} !== 3'b000 || out_data !== '0 || vec_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b b=%b o=%b d=%0h c=%0d expected all zero",
               out_valid, busy, overflow, out_data, vec_count);
    end
  endtask

  task automatic test_basic();
    send(1, 1'b1);
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL first_latency: got v=%b b=%b expected 1 1", out_valid, busy);
    end
    tick(); tick(); tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL last_word_valid: got %b expected 1", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || vec_count !== 16'd1 || out_data !== 16'd4) begin
      bad++;
      $display("FAIL wait_state: got v=%b b=%b c=%0d d=%0h expected 0 1 1 4",
               out_valid, busy, vec_count, out_data);
    end
    tick(); tick();
    pulse_done();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL done_to_idle: got busy=%b expected 0", busy);
    end
    tick();
    send(16'h50, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h50) begin
      bad++; $display("FAIL restart_latency: got v=%b d=%0h expected 1 50", out_valid, out_data);
    end
    tick(); tick(); tick(); tick();
    pulse_done();
    total++;
    if (busy !== 1'b0 || vec_count !== 16'd2) begin
      bad++; $display("FAIL second_vector: got b=%b c=%0d expected 0 2", busy, vec_count);
    end
  endtask

  task automatic test_back_to_back();
    send(16'h100, 1'b1);
    tick(); tick(); tick(); tick();
    up_data   = mk(16'h200);
    up_valid  = 1'b1;
    down_done = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(DW'(16'h200 + i));
    tick();
    up_valid  = 1'b0;
    down_done = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h200 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got v=%b d=%0h o=%b expected 1 200 0", out_valid, out_data, overflow);
    end
    tick(); tick(); tick(); tick();
    pulse_done();
    total++;
    if (busy !== 1'b0 || vec_count !== 16'd4) begin
      bad++; $display("FAIL b2b_end: got b=%b c=%0d expected 0 4", busy, vec_count);
    end
  endtask

  task automatic test_overflow();
    send(16'h300, 1'b1);
    // down_done during STREAM must be ignored
    down_done = 1'b1;
    send(16'h400, 1'b0);
    down_done = 1'b0;
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL overflow_set: got o=%b b=%b expected 1 1", overflow, busy);
    end
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL overflow_wait: got b=%b v=%b expected 1 0", busy, out_valid);
    end
    pulse_done();
    tick(); tick(); tick(); tick();
    total++;
    if (busy !== 1'b0 || vec_count !== 16'd5 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_after: got b=%b c=%0d o=%b expected 0 5 1", busy, vec_count, overflow);
    end
  endtask

  task automatic test_reset_mid_stream();
    send(16'h600, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    total++;
    if (out_valid !== 1'b0 || vec_count !== 16'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b c=%0d b=%b o=%b expected 0 0 0 0",
               out_valid, vec_count, busy, overflow);
    end
    tick(); tick(); tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_abandon: got v=%b expected 0", out_valid);
    end
  endtask

`ifdef DOUBLE_BUF_EN
  task automatic test_double_buf();
    do_reset();
    send(16'h700, 1'b1);
    send(16'h800, 1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL pend_store: got o=%b expected 0", overflow);
    end
    send(16'h900, 1'b0);
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL pend_overflow: got o=%b expected 1", overflow);
    end
    tick(); tick();
    pulse_done();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h800) begin
      bad++; $display("FAIL pend_promote: got v=%b d=%0h expected 1 800", out_valid, out_data);
    end
    tick(); tick(); tick(); tick();
    pulse_done();
    tick(); tick(); tick(); tick();
    total++;
    if (busy !== 1'b0 || vec_count !== 16'd2) begin
      bad++; $display("FAIL pend_end: got b=%b c=%0d expected 0 2", busy, vec_count);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    up_data   = '0;
    up_valid  = 1'b0;
    down_done = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_reset_mid_stream();
`ifdef DOUBLE_BUF_EN
    test_double_buf();
`endif
    tick(); tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL words_missing: got %0d unsent words expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
